// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types, opcodes and legality helpers for the ntt command path
//
// Contents:
//   OPC_*            engine opcodes accepted by ntt_engine
//   SLOT_MAX         highest legal slot index
//   cmd_t            packed host command {opcode, slot, dma_addr} (60 bits)
//   state_t          issuer FSM states
//   is_legal_opcode  opcode screen
//   is_legal_cmd     full command screen (opcode and slot)
package ntt_pkg;

  localparam logic [7:0] OPC_LOAD  = 8'h02;
  localparam logic [7:0] OPC_STORE = 8'h03;
  localparam logic [7:0] OPC_NTT   = 8'h10;
  localparam logic [7:0] OPC_INTT  = 8'h11;

  localparam logic [3:0] SLOT_MAX  = 4'd3;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  slot;
    logic [47:0] dma_addr;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  function automatic logic is_legal_opcode(input logic [7:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_NTT) || (op == OPC_INTT);
  endfunction

  function automatic logic is_legal_cmd(input cmd_t c);
    return is_legal_opcode(c.opcode) && (c.slot <= SLOT_MAX);
  endfunction

endpackage

// File: rtl/ntt_cmd_fifo.sv
// rtl/ntt_cmd_fifo.sv - synchronous FIFO of cmd_t entries
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (flushes the FIFO)
//   push         write push_data when not full
//   push_data    command to enqueue
//   pop          advance the head when not empty
//   pop_data     current head (valid while !empty)
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
module ntt_cmd_fifo
  import ntt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            push_en;
  logic            pop_en;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ntt_cmd_issuer.sv
// rtl/ntt_cmd_issuer.sv - buffers host commands and issues them to ntt_engine with a watchdog
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   in_valid/in_ready                  host push handshake (in_ready = FIFO not full)
//   in_opcode/in_slot/in_dma_addr      host command fields
//   cmd_valid                          one-cycle issue pulse to the engine
//   cmd_opcode/cmd_slot/cmd_dma_addr   command fields, held from issue until next pop
//   eng_ready                          engine ready
//   done_pulse                         issued command completed
//   err_illegal                        popped command dropped as illegal
//   err_timeout                        sticky watchdog expiry, cleared by rst only
//   busy                               FIFO non-empty or FSM not idle
//   issued_count                       completed commands, wrapping
module ntt_cmd_issuer
  import ntt_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [3:0]  in_slot,
  input  logic [47:0] in_dma_addr,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [3:0]  cmd_slot,
  output logic [47:0] cmd_dma_addr,
  input  logic        eng_ready,
  output logic        done_pulse,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        busy,
  output logic [31:0] issued_count
);

  state_t                  state_q;
  state_t                  state_d;
  cmd_t                    cmd_q;
  cmd_t                    fifo_head;
  cmd_t                    fifo_wdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [TIMEOUT_W-1:0]    wd_q;
  logic [TIMEOUT_W-1:0]    wd_inc;
  logic                    wd_expire;
  logic                    err_timeout_q;
  logic [31:0]             issued_q;

  assign fifo_wdata = {in_opcode, in_slot, in_dma_addr};
  assign fifo_push  = in_valid && !fifo_full;
  assign wd_inc     = wd_q + TIMEOUT_W'(1);

  ntt_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready     = !fifo_full;
  assign busy         = (fifo_count != '0) || (state_q != S_IDLE);
  assign cmd_opcode   = cmd_q.opcode;
  assign cmd_slot     = cmd_q.slot;
  assign cmd_dma_addr = cmd_q.dma_addr;
  assign err_timeout  = err_timeout_q;
  assign issued_count = issued_q;

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    cmd_valid   = 1'b0;
    err_illegal = 1'b0;
    done_pulse  = 1'b0;
    wd_expire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && eng_ready) begin
          fifo_pop = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!is_legal_cmd(cmd_q)) begin
          err_illegal = 1'b1;
          state_d     = S_IDLE;
        end else if (eng_ready) begin
          // Only move to issue after a ready cycle, so cmd_valid always
          // follows a cycle in which the engine showed ready.
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        state_d   = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (wd_inc == '1) begin
          wd_expire = 1'b1;
          state_d   = S_HALT;
        end else if (!eng_ready) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // Completion wins over a simultaneous watchdog expiry.
        if (eng_ready) begin
          done_pulse = 1'b1;
          state_d    = S_IDLE;
        end else if (wd_inc == '1) begin
          wd_expire = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
      issued_q      <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        cmd_q <= fifo_head;
      end
      if (state_d == S_ISSUE) begin
        wd_q <= '0;
      end else if ((state_q == S_WAIT_LO) || (state_q == S_WAIT_HI)) begin
        wd_q <= wd_inc;
      end
      if (wd_expire) begin
        err_timeout_q <= 1'b1;
      end
      if (done_pulse) begin
        issued_q <= issued_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_cmd_issuer.sv
// tb/tb_ntt_cmd_issuer.sv - scoreboard bench for ntt_cmd_issuer with behavioural engine
module tb_ntt_cmd_issuer;

  localparam int DEPTH = 8;
  localparam int TW    = 6;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [3:0]  in_slot;
  logic [47:0] in_dma_addr;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic        eng_ready;
  logic        done_pulse;
  logic        err_illegal;
  logic        err_timeout;
  logic        busy;
  logic [31:0] issued_count;

  ntt_cmd_issuer #(
    .DEPTH     (DEPTH),
    .TIMEOUT_W (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_slot      (in_slot),
    .in_dma_addr  (in_dma_addr),
    .cmd_valid    (cmd_valid),
    .cmd_opcode   (cmd_opcode),
    .cmd_slot     (cmd_slot),
    .cmd_dma_addr (cmd_dma_addr),
    .eng_ready    (eng_ready),
    .done_pulse   (done_pulse),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout),
    .busy         (busy),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit          illegal;
    logic [7:0]  op;
    logic [3:0]  slot;
    logic [47:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_issued = 0;
  int          done_seen = 0;
  int          illegal_seen = 0;
  int          last_issue_cyc = 0;
  logic [59:0] last_fields = '0;
  bit          prev_rdy = 1'b0;

  // Engine model: ready drops the cycle after acceptance, engine stays busy
  // busy_len cycles, then idles one cycle with ready low before raising it.
  bit e_idle = 1'b1;
  bit e_rdy  = 1'b1;
  int e_cnt  = 0;
  int busy_len = 5;
  bit hang  = 1'b0;
  bit stall = 1'b0;

  assign eng_ready = e_rdy && !stall;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      e_idle <= 1'b1;
      e_rdy  <= 1'b1;
      e_cnt  <= 0;
    end else if (e_idle && cmd_valid) begin
      e_idle <= 1'b0;
      e_rdy  <= 1'b0;
      e_cnt  <= busy_len;
    end else if (!e_idle) begin
      e_rdy <= 1'b0;
      if (!hang) begin
        if (e_cnt <= 1) e_idle <= 1'b1;
        else            e_cnt  <= e_cnt - 1;
      end
    end else begin
      e_rdy <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [7:0] op, input logic [3:0] s);
    return (op == 8'h02 || op == 8'h03 || op == 8'h10 || op == 8'h11) && (s < 4'd4);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT issues or drops a command.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        check("spacing_prev_ready", 64'(prev_rdy), 64'd1);
        check("engine_idle_at_issue", 64'(e_idle), 64'd1);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cmd_valid: got op %0h slot %0h expected no issue", cmd_opcode, cmd_slot);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.illegal) begin
            n_fail++;
            $display("FAIL issue_of_illegal: got issue op %0h expected err_illegal", cmd_opcode);
          end
          check("issue_fields", {4'h0, cmd_opcode, cmd_slot, cmd_dma_addr}, {4'h0, e.op, e.slot, e.addr});
          last_fields    = {e.op, e.slot, e.addr};
          last_issue_cyc = cyc;
        end
      end
      if (err_illegal) begin
        illegal_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err_illegal: got pulse expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!e.illegal) begin
            n_fail++;
            $display("FAIL dropped_legal: got err_illegal expected issue op %0h slot %0h", e.op, e.slot);
          end
        end
      end
      if (done_pulse) done_seen++;
      if (!e_idle) begin
        check("fields_held", {4'h0, cmd_opcode, cmd_slot, cmd_dma_addr}, {4'h0, last_fields});
      end
    end
    prev_rdy = eng_ready;
  end

  task automatic push_cmd(input logic [7:0] op, input logic [3:0] s, input logic [47:0] a,
                          input bit record, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1; in_opcode = op; in_slot = s; in_dma_addr = a;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (record) begin
          exp_q.push_back({!legal(op, s), op, s, a});
          if (legal(op, s)) exp_issued++;
        end
        acc_cyc = cyc;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("push_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && e_idle && eng_ready) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    check({name, "_drained"}, 64'(done), 64'd1);
    check({name, "_issued_count"}, 64'(issued_count), 64'(exp_issued));
    check({name, "_done_pulses"}, 64'(done_seen), 64'(exp_issued));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_issued = 0; done_seen = 0; illegal_seen = 0;
    hang = 1'b0; stall = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int base_ill;
    int t_seen;
    logic [63:0] r;
    logic [7:0]  op;
    logic [3:0]  s;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_slot = '0; in_dma_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_fields", {4'h0, cmd_opcode, cmd_slot, cmd_dma_addr}, 64'd0);
    check("rst_done", 64'(done_pulse), 64'd0);
    check("rst_err_illegal", 64'(err_illegal), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issued_count", 64'(issued_count), 64'd0);
    @(posedge clk); #1;

    // Single LOAD with latency check
    busy_len = 5;
    push_cmd(8'h02, 4'd1, 48'h1000, 1'b1, c);
    drain("load");
    check("load_latency", 64'(last_issue_cyc - c), 64'd3);

    // Back-to-back legal commands
    busy_len = 3;
    push_cmd(8'h10, 4'd0, 48'h0, 1'b1, c);
    push_cmd(8'h11, 4'd2, 48'h0, 1'b1, c);
    push_cmd(8'h03, 4'd3, 48'h2000, 1'b1, c);
    drain("b2b");
    check("b2b_count4", 64'(issued_count), 64'd4);

    // Illegal screening
    base_ill = illegal_seen;
    push_cmd(8'h55, 4'd0, 48'h0, 1'b1, c);
    push_cmd(8'h10, 4'd7, 48'h0, 1'b1, c);
    push_cmd(8'h10, 4'd0, 48'h0, 1'b1, c);
    drain("illegal");
    check("illegal_pulses", 64'(illegal_seen - base_ill), 64'd2);

    // FIFO full with stalled engine
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_cmd(8'h10, 4'(i % 4), 48'(i), 1'b1, c);
    in_valid = 1'b1; in_opcode = 8'h11; in_slot = 4'd1; in_dma_addr = 48'hdead;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    drain("full");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: op = 8'h02;
        1: op = 8'h03;
        2: op = 8'h10;
        3: op = 8'h11;
        4: op = 8'($urandom());
        default: op = 8'h10;
      endcase
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      r = {$urandom(), $urandom()};
      busy_len = $urandom_range(1, 8);
      push_cmd(op, s, r[47:0], 1'b1, c);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("random");

    // Reset while waiting on the engine with commands queued
    busy_len = 30;
    for (int i = 0; i < 4; i++) push_cmd(8'h10, 4'(i), 48'h0, 1'b1, c);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!e_idle) break;
    end
    @(negedge clk);
    @(negedge clk);
    check("midrst_queued", 64'(exp_q.size()), 64'd3);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_issued_count", 64'(issued_count), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // Watchdog: engine never raises ready again
    hang = 1'b1;
    push_cmd(8'h10, 4'd1, 48'h0, 1'b1, c);
    t_seen = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (err_timeout) begin
        t_seen = cyc;
        break;
      end
    end
    check("timeout_delay", 64'(t_seen - last_issue_cyc), 64'd64);
    check("halt_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    push_cmd(8'h11, 4'd2, 48'h0, 1'b0, c);
    check("halt_push_accepted", 64'(c >= 0), 64'd1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("timeout_sticky", 64'(err_timeout), 64'd1);
    check("halt_no_done", 64'(done_seen), 64'd0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("post_rst_timeout", 64'(err_timeout), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    busy_len = 2;
    push_cmd(8'h02, 4'd3, 48'hbeef, 1'b1, c);
    drain("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
